motor_drive: RTL and testbench

//  Downstream of the tracking/u-turn controller: converts its 2-bit motor command
//  (00 stop, 01 forward, 10 backward, 11 brake) into H-bridge gate signals.

---
 rtl/motor_drive_pkg.sv | 36 +++
 rtl/motor_drive_if.sv | 14 +
 rtl/motor_drive_pwm_gen.sv | 29 ++
 rtl/motor_drive.sv | 110 +++++++++++
 tb/tb_motor_drive.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/motor_drive_pkg.sv
// Shared motor command codes and drive-state definitions for the motor drive
// and the tracking/u-turn controller that feeds it.
package motor_drive_pkg;

  typedef logic [1:0] motor_cmd_t;

  localparam motor_cmd_t MOTOR_STOP  = 2'b00;
  localparam motor_cmd_t MOTOR_FOR   = 2'b01;
  localparam motor_cmd_t MOTOR_BACK  = 2'b10;
  localparam motor_cmd_t MOTOR_BRAKE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN_FWD  = 3'd1,
    ST_RUN_BACK = 3'd2,
    ST_DEAD     = 3'd3,
    ST_BRAKE    = 3'd4
  } state_t;

  function automatic logic is_run(input state_t s);
    return (s == ST_RUN_FWD) || (s == ST_RUN_BACK);
  endfunction

  // Target state for a fresh command from a stopped or braked bridge.
  function automatic state_t cmd_to_state(input motor_cmd_t cmd);
    state_t s;
    case (cmd)
      MOTOR_FOR:   s = ST_RUN_FWD;
      MOTOR_BACK:  s = ST_RUN_BACK;
      MOTOR_BRAKE: s = ST_BRAKE;
      default:     s = ST_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/motor_drive_if.sv
// Command/gate bundle between the tracking controller (master) and the
// H-bridge drive (slave).
interface motor_drive_if;
  import motor_drive_pkg::*;

  motor_cmd_t motor;
  logic       ina;
  logic       inb;
  logic       at_speed;
  logic       reversing;

  modport master (output motor, input ina, input inb, input at_speed, input reversing);
  modport slave  (input motor, output ina, output inb, output at_speed, output reversing);
endinterface

// File: rtl/motor_drive_pwm_gen.sv
// Free-running PWM period counter with duty compare; pwm is high while the
// counter is below duty.
module motor_drive_pwm_gen #(
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_W     = 10
) (
  input  logic              clkus,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm
);
  localparam int CNT_W = $clog2(PWM_PERIOD + 1);
  localparam int CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;

  logic [CNT_W-1:0] pwm_cnt_reg;

  always_ff @(posedge clkus or posedge rst) begin
    if (rst) begin
      pwm_cnt_reg <= '0;
    end else if (pwm_cnt_reg == CNT_W'(PWM_PERIOD - 1)) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + CNT_W'(1);
    end
  end

  // Compare at a common width so duty == PWM_PERIOD gives a constant high.
  assign pwm = CMP_W'(pwm_cnt_reg) < CMP_W'(duty);
endmodule

// File: rtl/motor_drive.sv
// H-bridge drive: command FSM with soft-start ramp, fixed-frequency PWM and a
// coast dead-time on direct direction reversals.
module motor_drive
  import motor_drive_pkg::*;
#(
  parameter int PWM_PERIOD    = 1000,
  parameter int DUTY_MAX      = 800,
  parameter int RAMP_STEP     = 10,
  parameter int RAMP_INTERVAL = 1000,
  parameter int DEAD_TIME     = 20000
) (
  input  logic         clkus,
  input  logic         rst,
  motor_drive_if.slave bus
);
  localparam int DUTY_W = $clog2(DUTY_MAX + 1);
  localparam int RAMP_W = $clog2(RAMP_INTERVAL + 1);
  localparam int DEAD_W = $clog2(DEAD_TIME + 1);

  state_t            state_reg, state_next;
  logic [DUTY_W-1:0] duty_reg, duty_next;
  logic [DUTY_W:0]   duty_sum;
  logic [RAMP_W-1:0] ramp_cnt_reg, ramp_cnt_next;
  logic [DEAD_W-1:0] dead_cnt_reg, dead_cnt_next;
  logic [1:0]        leg_reg, leg_next;  // {ina, inb}
  logic              stay_run;
  logic              pwm;

  always_ff @(posedge clkus or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      duty_reg     <= '0;
      ramp_cnt_reg <= '0;
      dead_cnt_reg <= '0;
      leg_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      duty_reg     <= duty_next;
      ramp_cnt_reg <= ramp_cnt_next;
      dead_cnt_reg <= dead_cnt_next;
      leg_reg      <= leg_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.motor == MOTOR_BRAKE) begin
      state_next = ST_BRAKE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_BRAKE: state_next = cmd_to_state(bus.motor);
        ST_RUN_FWD: begin
          if (bus.motor == MOTOR_STOP)      state_next = ST_IDLE;
          else if (bus.motor == MOTOR_BACK) state_next = ST_DEAD;
        end
        ST_RUN_BACK: begin
          if (bus.motor == MOTOR_STOP)     state_next = ST_IDLE;
          else if (bus.motor == MOTOR_FOR) state_next = ST_DEAD;
        end
        // Command changes during the window neither shorten nor restart it.
        ST_DEAD: begin
          if (dead_cnt_reg == DEAD_W'(DEAD_TIME - 1)) state_next = cmd_to_state(bus.motor);
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Any state change (including run entry) restarts the ramp from zero duty.
  always_comb begin
    stay_run      = is_run(state_reg) && (state_next == state_reg);
    duty_sum      = {1'b0, duty_reg} + (DUTY_W + 1)'(RAMP_STEP);
    duty_next     = '0;
    ramp_cnt_next = '0;
    dead_cnt_next = '0;
    if (stay_run) begin
      if (ramp_cnt_reg == RAMP_W'(RAMP_INTERVAL - 1)) begin
        duty_next = (duty_sum > (DUTY_W + 1)'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX)
                                                          : duty_sum[DUTY_W-1:0];
      end else begin
        ramp_cnt_next = ramp_cnt_reg + RAMP_W'(1);
        duty_next     = duty_reg;
      end
    end
    if ((state_reg == ST_DEAD) && (state_next == ST_DEAD)) begin
      dead_cnt_next = dead_cnt_reg + DEAD_W'(1);
    end
  end

  motor_drive_pwm_gen #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_W     (DUTY_W)
  ) u_pwm (
    .clkus (clkus),
    .rst   (rst),
    .duty  (duty_reg),
    .pwm   (pwm)
  );

  // Leg 1 drives ina (forward), leg 0 drives inb (backward); brake closes both.
  for (genvar gi = 0; gi < 2; gi++) begin : g_leg
    localparam state_t LEG_RUN = (gi == 1) ? ST_RUN_FWD : ST_RUN_BACK;
    assign leg_next[gi] = (state_reg == ST_BRAKE) || ((state_reg == LEG_RUN) && pwm);
  end

  assign bus.ina       = leg_reg[1];
  assign bus.inb       = leg_reg[0];
  assign bus.at_speed  = is_run(state_reg) && (duty_reg == DUTY_W'(DUTY_MAX));
  assign bus.reversing = (state_reg == ST_DEAD);
endmodule

// File: tb/tb_motor_drive.sv
// Bench for motor_drive: directed scenarios plus randomized command streams,
// checked against a behavioural model of the drive rules.
module tb_motor_drive;
  localparam int PP = 10;
  localparam int DM = 8;
  localparam int RS = 3;
  localparam int RI = 5;
  localparam int DT = 6;

  logic clkus = 1'b0;
  logic rst   = 1'b1;
  int   errors = 0;
  int   checks = 0;

  motor_drive_if bus ();
  motor_drive_if bus6 ();

  motor_drive #(.PWM_PERIOD(PP), .DUTY_MAX(DM), .RAMP_STEP(RS),
                .RAMP_INTERVAL(RI), .DEAD_TIME(DT))
    dut (.clkus(clkus), .rst(rst), .bus(bus));

  motor_drive #(.PWM_PERIOD(PP), .DUTY_MAX(PP), .RAMP_STEP(RS),
                .RAMP_INTERVAL(RI), .DEAD_TIME(DT))
    dut6 (.clkus(clkus), .rst(rst), .bus(bus6));

  always #5 clkus = ~clkus;

  // Model modes: 0 idle, 1 forward, 2 backward, 3 dead, 4 brake.
  int   m_mode = 0, m_next, m_run = 0, m_dead = 0, m_tick = 0, m_duty;
  logic m_ina = 1'b0, m_inb = 1'b0, m_pwm, m_running;
  logic [3:0] obs, expv;

  function automatic int pick(input logic [1:0] cmd);
    return (cmd == 2'b01) ? 1 : (cmd == 2'b10) ? 2 : (cmd == 2'b11) ? 4 : 0;
  endfunction

  always_comb begin
    m_running = (m_mode == 1) || (m_mode == 2);
    m_duty    = m_running ? (m_run / RI) * RS : 0;
    if (m_duty > DM) m_duty = DM;
    m_pwm  = (m_tick % PP) < m_duty;
    m_next = m_mode;
    if (bus.motor == 2'b11)                m_next = 4;
    else if (m_mode == 0 || m_mode == 4)   m_next = pick(bus.motor);
    else if (m_mode == 1)                  m_next = (bus.motor == 2'b00) ? 0 : (bus.motor == 2'b10) ? 3 : 1;
    else if (m_mode == 2)                  m_next = (bus.motor == 2'b00) ? 0 : (bus.motor == 2'b01) ? 3 : 2;
    else if (m_dead == DT - 1)             m_next = pick(bus.motor);
  end

  always @(posedge clkus or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_run <= 0; m_dead <= 0; m_tick <= 0;
      m_ina <= 1'b0; m_inb <= 1'b0;
    end else begin
      m_ina  <= (m_mode == 4) || (m_mode == 1 && m_pwm);
      m_inb  <= (m_mode == 4) || (m_mode == 2 && m_pwm);
      m_tick <= m_tick + 1;
      m_mode <= m_next;
      m_run  <= (m_next == m_mode) ? m_run + 1 : 0;
      m_dead <= (m_next == m_mode) ? m_dead + 1 : 0;
    end
  end

  assign obs  = {bus.ina, bus.inb, bus.at_speed, bus.reversing};
  assign expv = {m_ina, m_inb, m_running && (m_duty == DM), m_mode == 3};

  task automatic test_reset();
    bus.motor = 2'b00; bus6.motor = 2'b00; rst = 1'b1;
    repeat (3) @(negedge clkus);
    checks++; if (obs !== 4'b0000) begin errors++; $display("FAIL reset_state obs=%b exp=0000", obs); end
    checks++; if ({bus6.ina, bus6.inb} !== 2'b00) begin errors++; $display("FAIL reset_state6 obs=%b exp=00", {bus6.ina, bus6.inb}); end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clkus);
      checks++; if (obs !== expv) begin errors++; $display("FAIL reset_idle obs=%b exp=%b", obs, expv); end
    end
    $display("test_reset: done");
  endtask

  task automatic test_reset_mid();
    bus.motor = 2'b01;
    repeat (25) begin
      @(negedge clkus);
      checks++; if (obs !== expv) begin errors++; $display("FAIL mid_run obs=%b exp=%b", obs, expv); end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.ina, bus.inb} !== 2'b00) begin errors++; $display("FAIL async_reset ina_inb=%b exp=00", {bus.ina, bus.inb}); end
    checks++; if (obs !== expv) begin errors++; $display("FAIL async_reset_model obs=%b exp=%b", obs, expv); end
    @(negedge clkus);
    rst = 1'b0; bus.motor = 2'b00;
    repeat (10) begin
      @(negedge clkus);
      checks++; if (obs !== 4'b0000) begin errors++; $display("FAIL post_reset_stop obs=%b exp=0000", obs); end
    end
    $display("test_reset_mid: done");
  endtask

  task automatic test_ramp();
    int ina_hi = 0;
    bus.motor = 2'b01;
    for (int i = 0; i < 60; i++) begin
      @(negedge clkus);
      checks++; if (obs !== expv) begin errors++; $display("FAIL ramp cyc=%0d obs=%b exp=%b", i, obs, expv); end
      if (i == 30) begin
        checks++; if (bus.at_speed !== 1'b1) begin errors++; $display("FAIL ramp_at_speed obs=%b exp=1", bus.at_speed); end
      end
      if (i >= 40) ina_hi += int'(bus.ina);
    end
    checks++; if (ina_hi != 16) begin errors++; $display("FAIL ramp_duty ina_high=%0d exp=16", ina_hi); end
    $display("test_ramp: ina high %0d of 20 at speed", ina_hi);
  endtask

  task automatic test_reversal();
    int rev = 0, ina_hi = 0, inb_hi = 0;
    bus.motor = 2'b10;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkus);
      checks++; if (obs !== expv) begin errors++; $display("FAIL reversal cyc=%0d obs=%b exp=%b", i, obs, expv); end
      rev += int'(bus.reversing);
      if (i >= 1)  ina_hi += int'(bus.ina);
      if (i >= 30) inb_hi += int'(bus.inb);
    end
    checks++; if (rev != DT) begin errors++; $display("FAIL dead_len got=%0d exp=%0d", rev, DT); end
    checks++; if (ina_hi != 0) begin errors++; $display("FAIL reversal_ina got=%0d exp=0", ina_hi); end
    checks++; if (inb_hi != 8) begin errors++; $display("FAIL reversal_inb got=%0d exp=8", inb_hi); end
    $display("test_reversal: dead=%0d inb high %0d of 10", rev, inb_hi);
  endtask

  task automatic test_brake_abort();
    bus.motor = 2'b01;
    repeat (2) begin
      @(negedge clkus);
      checks++; if (obs !== expv) begin errors++; $display("FAIL brake_pre obs=%b exp=%b", obs, expv); end
    end
    bus.motor = 2'b11;
    @(negedge clkus);
    checks++; if (bus.reversing !== 1'b0) begin errors++; $display("FAIL brake_abort reversing=%b exp=0", bus.reversing); end
    @(negedge clkus);
    checks++; if ({bus.ina, bus.inb} !== 2'b11) begin errors++; $display("FAIL brake_gates obs=%b exp=11", {bus.ina, bus.inb}); end
    bus.motor = 2'b01;
    @(negedge clkus);
    checks++; if (bus.at_speed !== 1'b0) begin errors++; $display("FAIL brake_to_run at_speed=%b exp=0", bus.at_speed); end
    repeat (20) begin
      @(negedge clkus);
      checks++; if (obs !== expv) begin errors++; $display("FAIL brake_run obs=%b exp=%b", obs, expv); end
    end
    $display("test_brake_abort: done");
  endtask

  task automatic test_dead_toggle();
    int rev = 0;
    bus.motor = 2'b10;
    for (int i = 0; i < 15; i++) begin
      @(negedge clkus);
      checks++; if (obs !== expv) begin errors++; $display("FAIL dead_toggle cyc=%0d obs=%b exp=%b", i, obs, expv); end
      rev += int'(bus.reversing);
      if (i == 0) bus.motor = 2'b01;
      if (i == 1) bus.motor = 2'b00;
    end
    checks++; if (rev != DT) begin errors++; $display("FAIL dead_toggle_len got=%0d exp=%0d", rev, DT); end
    checks++; if (obs !== 4'b0000) begin errors++; $display("FAIL dead_toggle_idle obs=%b exp=0000", obs); end
    $display("test_dead_toggle: dead=%0d", rev);
  endtask

  task automatic test_full_duty();
    bus6.motor = 2'b01;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkus);
      if (i <= 5) begin
        checks++; if (bus6.ina !== 1'b0) begin errors++; $display("FAIL zero_duty cyc=%0d ina=%b exp=0", i, bus6.ina); end
      end
      if (i >= 21) begin
        checks++; if ({bus6.ina, bus6.at_speed} !== 2'b11) begin errors++; $display("FAIL full_duty cyc=%0d ina_at=%b exp=11", i, {bus6.ina, bus6.at_speed}); end
      end
    end
    bus6.motor = 2'b00;
    $display("test_full_duty: done");
  endtask

  task automatic test_random();
    logic [1:0] cmd;
    int hold;
    for (int n = 0; n < 120; n++) begin
      cmd  = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 20);
      bus.motor = cmd;
      repeat (hold) begin
        @(negedge clkus);
        checks++; if (obs !== expv) begin errors++; $display("FAIL random seg=%0d obs=%b exp=%b", n, obs, expv); end
      end
      $display("random seg=%0d cmd=%b hold=%0d", n, cmd, hold);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_ramp();
    test_reversal();
    test_brake_abort();
    test_dead_toggle();
    test_full_duty();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
